reg_write_ctrl: RTL and testbench
=================================

# reg_write_ctrl

Write-side controller for the pipeline register file. It merges two result sources into the register file's single write port (`w_write_reg`, `reg_des`, `reg_data`):

- **Source A:** the in-order writeback stage, which can never stall.
- **Source B:** long-latency units (mult/div, late loads). B results are buffered in a small FIFO and drained in cycles when A is idle.

It also gives decode a pending-write scoreboard, so decode can stall on registers whose B result has not yet been written.

## Interface
Parameters:
- `FIFO_DEPTH`, default 2: source-B buffer entries; power of two, ≥2.

Ports:
- `clk` in 1: the only clock.
- `rst` in 1: synchronous, active-high reset.
- `a_valid` in 1: source-A write request this cycle; there is no backpressure.
- `a_addr` in 5: source-A destination register.
- `a_data` in 32: source-A write data.
- `b_valid` in 1: source-B write request.
- `b_addr` in 5: source-B destination register.
- `b_data` in 32: source-B write data.
- `b_ready` out 1: source-B request is accepted at the edge where `b_valid && b_ready`.
- `w_write_reg` out 1: register-file write enable (1 = `WriteEnable`); registered.
- `reg_des` out 5: register-file write address; registered.
- `reg_data` out 32: register-file write data; registered.
- `q_rs` in 5: decode rs register to check.
- `q_rt` in 5: decode rt register to check.
- `q_rs_pend` out 1: a live B write to `q_rs` is queued; combinational.
- `q_rt_pend` out 1: a live B write to `q_rt` is queued; combinational.

## Operation
- **FIFO entry format:** {live, addr[4:0], data[31:0]}.
- **Register 0:**
  - A write with `a_addr==0` is ignored.
  - B request with `b_addr==0` is accepted (if ready) and discarded; it is not enqueued.
- **B accept:** `b_ready = !full && !rst`. It does not account for a same-cycle pop. An accepted request is enqueued at the tail with live=1.
- **Output register update at each edge, in priority order:**
  1. `a_valid && a_addr!=0`: load A, `w_write_reg`=1.
  2. Else, FIFO non-empty: pop head. If head is live, load it with `w_write_reg`=1. If head is dead, `w_write_reg`=0.
  3. Else: `w_write_reg`=0.
- When `w_write_reg`=0, `reg_des` and `reg_data` hold their previous values.
- **WAW squash:**
  - A is always the newer instruction.
  - When A writes addr X (X≠0), every queued entry with addr X becomes live=0 at that edge.
  - An entry for addr X enqueued at that same edge also becomes live=0.
  - Dead entries still occupy their slot until popped.
- **Scoreboard:** `q_rs_pend` = any FIFO entry that is live with addr==`q_rs` (likewise `q_rt_pend`).
  - The entry currently held in the output register is not reported.
  - Query address 0 always returns 0.
- **Order:** B entries are written in acceptance order. A is never reordered.

## Timing
- **Reset** (sync, `rst`=1 at an edge):
  - `w_write_reg`=0, `reg_des`=0, `reg_data`=0.
  - FIFO empty; all entries dead.
  - `q_*_pend`=0.
  - `b_ready`=0 while `rst` is high.
- **Reset mid-operation:** all queued B writes are lost, and no write is issued in the cycle after reset.
- **A latency:** `a_valid` in cycle N gives `w_write_reg`=1 with A addr/data in cycle N+1. The register file commits at the end of N+1. Throughput is 1 write/cycle.
- **B latency:** if accepted at edge E and A is idle in the cycle after E, the write is driven in the cycle after the next edge, i.e. 2 cycles after the acceptance cycle minimum. There is no B→output bypass.
- **B starvation:** B waits while A is valid every cycle. The FIFO fills, `b_ready` drops, and it rises again the cycle after the first pop.
- **Full FIFO with same-edge pop:** the push is still refused; `b_ready` was 0.
- **Scoreboard timing:** `q_*_pend` reflects FIFO state after the previous edge.
  - It rises in the cycle after acceptance.
  - It falls in the cycle after the pop or squash edge.

## Test plan
- **Reset:** hold `rst` 2 cycles with `a_valid`=1 and `b_valid`=1 → outputs 0, `b_ready`=0, nothing enqueued. Release → `b_ready`=1, `w_write_reg`=0.
- **A path:** cycle N: `a_valid` addr 5'h11 data 32'h1324 → cycle N+1: `w_write_reg`=1, `reg_des`=5'h11, `reg_data`=32'h1324. Then `a_valid`=0 → `w_write_reg`=0.
- **B queuing under A pressure:**
  - Stimulus: A valid every cycle for 4 cycles. B offers 5'h12/32'h1212 then 5'h13/32'h1313.
  - Both are accepted; then `b_ready`=0 with `FIFO_DEPTH`=2.
  - `q_rt_pend`=1 for `q_rt`=5'h12.
  - After A stops: writes 5'h12 then 5'h13 on consecutive cycles, and the pend flags clear.
- **WAW squash:**
  - Stimulus: B 5'h11/32'hAAAA queued; then A writes 5'h11/32'h1242.
  - Exactly one write to 5'h11 occurs, with data 32'h1242.
  - The dead entry's pop cycle has `w_write_reg`=0.
  - `q_rs_pend` for 5'h11 drops the cycle after the A edge.
- **Same-edge collision:** A 5'h14 and B 5'h14 at the same edge → the B entry is enqueued dead; only A's data is written.
- **Register 0:** A addr 0 and B addr 0 → no write is ever issued, `q_*_pend(0)`=0, and FIFO occupancy is unchanged.

Source files
------------

// File: rtl/reg_write_if.sv
// Write-port bundle between the result sources / decode and the register-file
// write controller.
interface reg_write_if;
  logic        a_valid;
  logic [4:0]  a_addr;
  logic [31:0] a_data;
  logic        b_valid;
  logic [4:0]  b_addr;
  logic [31:0] b_data;
  logic        b_ready;
  logic        w_write_reg;
  logic [4:0]  reg_des;
  logic [31:0] reg_data;
  logic [4:0]  q_rs;
  logic [4:0]  q_rt;
  logic        q_rs_pend;
  logic        q_rt_pend;

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data, q_rs, q_rt,
    input  b_ready, w_write_reg, reg_des, reg_data, q_rs_pend, q_rt_pend
  );

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data, q_rs, q_rt,
    output b_ready, w_write_reg, reg_des, reg_data, q_rs_pend, q_rt_pend
  );
endinterface

// File: rtl/reg_write_ctrl.sv
// Merges in-order writeback (A) and buffered long-latency results (B) onto the
// single register-file write port, with a pending-write scoreboard for decode.
module reg_write_ctrl #(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  reg_write_if.slave bus
);
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;

  logic [FIFO_DEPTH-1:0] live_q, live_d;
  logic [AW-1:0]         addr_q [FIFO_DEPTH];
  logic [AW-1:0]         addr_d [FIFO_DEPTH];
  logic [DW-1:0]         data_q [FIFO_DEPTH];
  logic [DW-1:0]         data_d [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  w_write_reg_q, w_write_reg_d;
  logic [AW-1:0]         reg_des_q, reg_des_d;
  logic [DW-1:0]         reg_data_q, reg_data_d;

  logic full, a_wr, push, pop;
  logic rs_hit, rt_hit;

  // Next-state: A has priority; B drains only when A is idle.
  always_comb begin
    full = (count_q == CNT_W'(FIFO_DEPTH));
    a_wr = bus.a_valid && (bus.a_addr != '0);
    push = bus.b_valid && !full && !rst && (bus.b_addr != '0);
    pop  = !a_wr && (count_q != '0);

    live_d        = live_q;
    addr_d        = addr_q;
    data_d        = data_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    w_write_reg_d = 1'b0;
    reg_des_d     = reg_des_q;
    reg_data_d    = reg_data_q;

    // A is always newer, so it kills any queued write to the same register.
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      if (a_wr && (addr_q[i] == bus.a_addr)) live_d[i] = 1'b0;
    end

    if (a_wr) begin
      w_write_reg_d = 1'b1;
      reg_des_d     = bus.a_addr;
      reg_data_d    = bus.a_data;
    end else if (pop) begin
      live_d[rd_ptr_q] = 1'b0;
      rd_ptr_d         = rd_ptr_q + PTR_W'(1);
      if (live_q[rd_ptr_q]) begin
        w_write_reg_d = 1'b1;
        reg_des_d     = addr_q[rd_ptr_q];
        reg_data_d    = data_q[rd_ptr_q];
      end
    end

    if (push) begin
      live_d[wr_ptr_q] = !(a_wr && (bus.b_addr == bus.a_addr));
      addr_d[wr_ptr_q] = bus.b_addr;
      data_d[wr_ptr_q] = bus.b_data;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end

    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      live_q        <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      w_write_reg_q <= 1'b0;
      reg_des_q     <= '0;
      reg_data_q    <= '0;
    end else begin
      live_q        <= live_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      w_write_reg_q <= w_write_reg_d;
      reg_des_q     <= reg_des_d;
      reg_data_q    <= reg_data_d;
    end
  end

  // Payload is qualified by live bits, so it needs no reset.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

  // Scoreboard over live queued entries only.
  always_comb begin
    rs_hit = 1'b0;
    rt_hit = 1'b0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      if (live_q[i] && (addr_q[i] == bus.q_rs)) rs_hit = 1'b1;
      if (live_q[i] && (addr_q[i] == bus.q_rt)) rt_hit = 1'b1;
    end
  end

  assign bus.b_ready     = !full && !rst;
  assign bus.w_write_reg = w_write_reg_q;
  assign bus.reg_des     = reg_des_q;
  assign bus.reg_data    = reg_data_q;
  assign bus.q_rs_pend   = rs_hit && (bus.q_rs != '0);
  assign bus.q_rt_pend   = rt_hit && (bus.q_rt != '0);
endmodule

// File: tb/tb_reg_write_ctrl.sv
// Self-checking bench for reg_write_ctrl: directed scenarios plus random
// traffic against a queue-based reference model.
module tb_reg_write_ctrl;
  localparam int unsigned DEPTH = 2;

  typedef struct {
    bit       live;
    bit [4:0] addr;
    bit [31:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  reg_write_if bus ();

  reg_write_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  ent_t      mq[$];
  bit        m_w    = 1'b0;
  bit [4:0]  m_des  = '0;
  bit [31:0] m_data = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_pend(input bit [4:0] a);
    if (a == 5'd0) return 1'b0;
    foreach (mq[i]) if (mq[i].live && mq[i].addr == a) return 1'b1;
    return 1'b0;
  endfunction

  // Apply one cycle of inputs (at negedge) and compare every output with the model.
  task automatic drive(input logic r, input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                       input logic [4:0] qs, input logic [4:0] qt);
    rst = r;
    bus.a_valid = av; bus.a_addr = aa; bus.a_data = ad;
    bus.b_valid = bv; bus.b_addr = ba; bus.b_data = bd;
    bus.q_rs = qs; bus.q_rt = qt;
    #1;
    check_eq("w_write_reg", 32'(bus.w_write_reg), 32'(m_w));
    check_eq("reg_des", 32'(bus.reg_des), 32'(m_des));
    check_eq("reg_data", bus.reg_data, m_data);
    check_eq("b_ready", 32'(bus.b_ready), 32'(!r && (mq.size() < DEPTH)));
    check_eq("q_rs_pend", 32'(bus.q_rs_pend), 32'(m_pend(qs)));
    check_eq("q_rt_pend", 32'(bus.q_rt_pend), 32'(m_pend(qt)));
  endtask

  task automatic drive_idle(input logic [4:0] qs, input logic [4:0] qt);
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, qs, qt);
  endtask

  // Advance one clock edge and update the model from the applied inputs.
  task automatic tick();
    bit        r, av, bv, acc, awr;
    bit [4:0]  aa, ba;
    bit [31:0] ad, bd;
    ent_t      e;
    r = rst; av = bus.a_valid; aa = bus.a_addr; ad = bus.a_data;
    bv = bus.b_valid; ba = bus.b_addr; bd = bus.b_data;
    @(posedge clk);
    if (r) begin
      mq.delete();
      m_w = 1'b0; m_des = '0; m_data = '0;
    end else begin
      acc = bv && (mq.size() < DEPTH);
      awr = av && (aa != 5'd0);
      if (awr) begin
        m_w = 1'b1; m_des = aa; m_data = ad;
        foreach (mq[i]) if (mq[i].addr == aa) mq[i].live = 1'b0;
      end else if (mq.size() > 0) begin
        e   = mq.pop_front();
        m_w = e.live;
        if (e.live) begin m_des = e.addr; m_data = e.data; end
      end else begin
        m_w = 1'b0;
      end
      if (acc && ba != 5'd0) begin
        e.live = !(awr && ba == aa); e.addr = ba; e.data = bd;
        mq.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  function automatic logic [4:0] rnd_addr();
    if ($urandom_range(0, 3) != 0) return 5'($urandom_range(0, 3));
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    rst = 1'b1;
    bus.a_valid = 1'b0; bus.a_addr = '0; bus.a_data = '0;
    bus.b_valid = 1'b0; bus.b_addr = '0; bus.b_data = '0;
    bus.q_rs = '0; bus.q_rt = '0;
    @(posedge clk);
    @(negedge clk);

    // Reset held with both sources requesting
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 5'h09, 32'h99, 1'b1, 5'h0A, 32'hAA, 5'h0A, 5'h09);
      check_eq("rst_b_ready", 32'(bus.b_ready), 32'd0);
      tick();
    end
    drive_idle(5'h0A, 5'h09);
    check_eq("rel_b_ready", 32'(bus.b_ready), 32'd1);
    check_eq("rel_w", 32'(bus.w_write_reg), 32'd0);
    check_eq("rel_des", 32'(bus.reg_des), 32'd0);
    check_eq("rel_pend", 32'(bus.q_rs_pend), 32'd0);
    tick();

    // A path
    drive(1'b0, 1'b1, 5'h11, 32'h1324, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    tick();
    drive_idle(5'd0, 5'd0);
    check_eq("a_w", 32'(bus.w_write_reg), 32'd1);
    check_eq("a_des", 32'(bus.reg_des), 32'h11);
    check_eq("a_data", bus.reg_data, 32'h1324);
    tick();
    drive_idle(5'd0, 5'd0);
    check_eq("a_idle_w", 32'(bus.w_write_reg), 32'd0);
    tick();

    // B queuing under continuous A
    drive(1'b0, 1'b1, 5'h01, 32'h101, 1'b1, 5'h12, 32'h1212, 5'd0, 5'h12);
    tick();
    drive(1'b0, 1'b1, 5'h02, 32'h102, 1'b1, 5'h13, 32'h1313, 5'd0, 5'h12);
    check_eq("bq_ready2", 32'(bus.b_ready), 32'd1);
    tick();
    drive(1'b0, 1'b1, 5'h03, 32'h103, 1'b0, 5'd0, 32'd0, 5'h13, 5'h12);
    check_eq("bq_full", 32'(bus.b_ready), 32'd0);
    check_eq("bq_rt_pend", 32'(bus.q_rt_pend), 32'd1);
    check_eq("bq_rs_pend", 32'(bus.q_rs_pend), 32'd1);
    tick();
    drive(1'b0, 1'b1, 5'h04, 32'h104, 1'b0, 5'd0, 32'd0, 5'h13, 5'h12);
    tick();
    drive_idle(5'h13, 5'h12);
    tick();
    drive_idle(5'h13, 5'h12);
    check_eq("bq_w1", 32'(bus.w_write_reg), 32'd1);
    check_eq("bq_des1", 32'(bus.reg_des), 32'h12);
    check_eq("bq_data1", bus.reg_data, 32'h1212);
    check_eq("bq_ready_back", 32'(bus.b_ready), 32'd1);
    tick();
    drive_idle(5'h13, 5'h12);
    check_eq("bq_des2", 32'(bus.reg_des), 32'h13);
    check_eq("bq_data2", bus.reg_data, 32'h1313);
    check_eq("bq_clr_rs", 32'(bus.q_rs_pend), 32'd0);
    check_eq("bq_clr_rt", 32'(bus.q_rt_pend), 32'd0);
    tick();

    // WAW squash of a queued B entry
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'h11, 32'hAAAA, 5'h11, 5'd0);
    tick();
    drive(1'b0, 1'b1, 5'h11, 32'h1242, 1'b0, 5'd0, 32'd0, 5'h11, 5'd0);
    check_eq("waw_pend_before", 32'(bus.q_rs_pend), 32'd1);
    tick();
    drive_idle(5'h11, 5'd0);
    check_eq("waw_pend_after", 32'(bus.q_rs_pend), 32'd0);
    check_eq("waw_des", 32'(bus.reg_des), 32'h11);
    check_eq("waw_data", bus.reg_data, 32'h1242);
    tick();
    drive_idle(5'h11, 5'd0);
    check_eq("waw_dead_pop", 32'(bus.w_write_reg), 32'd0);
    tick();

    // Same-edge A/B collision
    drive(1'b0, 1'b1, 5'h14, 32'h1414, 1'b1, 5'h14, 32'hBBBB, 5'h14, 5'd0);
    tick();
    drive_idle(5'h14, 5'h14);
    check_eq("col_pend", 32'(bus.q_rs_pend), 32'd0);
    check_eq("col_data", bus.reg_data, 32'h1414);
    tick();
    drive_idle(5'h14, 5'd0);
    check_eq("col_dead_pop", 32'(bus.w_write_reg), 32'd0);
    tick();

    // Register 0 from both sources
    drive(1'b0, 1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF, 5'd0, 5'd0);
    check_eq("r0_pend", 32'(bus.q_rt_pend), 32'd0);
    tick();
    drive_idle(5'd0, 5'd0);
    check_eq("r0_w", 32'(bus.w_write_reg), 32'd0);
    check_eq("r0_ready", 32'(bus.b_ready), 32'd1);
    tick();
    drive_idle(5'd0, 5'd0);
    check_eq("r0_w2", 32'(bus.w_write_reg), 32'd0);
    tick();

    // Reset while B entries are queued
    drive(1'b0, 1'b1, 5'h05, 32'h55, 1'b1, 5'h07, 32'h77, 5'h07, 5'd0);
    tick();
    drive(1'b1, 1'b1, 5'h06, 32'h66, 1'b0, 5'd0, 32'd0, 5'h07, 5'd0);
    tick();
    drive_idle(5'h07, 5'd0);
    check_eq("mrst_w", 32'(bus.w_write_reg), 32'd0);
    check_eq("mrst_pend", 32'(bus.q_rs_pend), 32'd0);
    tick();
    drive_idle(5'h07, 5'd0);
    check_eq("mrst_w2", 32'(bus.w_write_reg), 32'd0);
    tick();

    // Random traffic
    for (int n = 0; n < 2000; n++) begin
      drive(1'($urandom_range(0, 63) == 0),
            1'($urandom_range(0, 99) < 45), rnd_addr(), $urandom(),
            1'($urandom_range(0, 99) < 60), rnd_addr(), $urandom(),
            rnd_addr(), rnd_addr());
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
